// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures the synchronized high time of each pulse and maps it
// back to an 8-bit position code, flagging short/long pulses and loss of signal.
module servo_pulse_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int PULSE_MIN     = 50000,
    parameter int STEP          = 196,
    parameter int PULSE_MAX     = 105000,
    parameter int FRAME_TIMEOUT = 1250000,
    parameter int CNT_W         = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       servo_in,
    output logic [7:0] pos,
    output logic       pos_valid,
    output logic       err_short,
    output logic       err_long,
    output logic       signal_lost
);
    localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CNT_W-1:0] PMIN  = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0] PMAX  = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0] FTO   = CNT_W'(FRAME_TIMEOUT);
    localparam logic [CNT_W-1:0] FLUSH = CNT_W'(SYNC_STAGES);
    localparam logic [PW-1:0]    PLAST = PW'(STEP - 1);

    typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE, WAIT_FALL} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0]       frame_q, frame_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [7:0]             step_q, step_d;
    logic [7:0]             pos_q;
    logic                   pos_valid_q, err_short_q, err_long_q, signal_lost_q;
    logic                   sync_w, rise, fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], servo_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign rise   = sync_w & ~prev_q;
    assign fall   = ~sync_w & prev_q;

    // presc tracks (W-PULSE_MIN) mod STEP and step the saturated quotient, so the
    // position is ready the moment the fall is seen without any divider.
    always_comb begin
        wcnt_d  = wcnt_q + 1'b1;
        frame_d = (frame_q == FTO) ? frame_q : frame_q + 1'b1;
        presc_d = presc_q;
        step_d  = step_q;
        if (wcnt_q >= PMIN) begin
            if (presc_q == PLAST) begin
                presc_d = '0;
                if (step_q != 8'hFF) step_d = step_q + 8'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARM;
            wcnt_q        <= '0;
            frame_q       <= '0;
            presc_q       <= '0;
            step_q        <= '0;
            pos_q         <= '0;
            pos_valid_q   <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            signal_lost_q <= 1'b0;
        end else begin
            pos_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            // The frame counter measures time since the last rise, whatever the state.
            if (rise) begin
                frame_q <= '0;
            end else begin
                frame_q <= frame_d;
                if (frame_d == FTO) signal_lost_q <= 1'b1;
            end
            case (state_q)
                // Let the synchronizer flush before trusting a low, so a pulse in
                // progress at reset release is discarded rather than half-measured.
                ARM: begin
                    if (wcnt_q <= FLUSH) wcnt_q <= wcnt_d;
                    else if (!sync_w)    state_q <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        wcnt_q  <= CNT_W'(1);
                        presc_q <= '0;
                        step_q  <= '0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        state_q <= WAIT_RISE;
                        if (wcnt_q < PMIN) begin
                            err_short_q <= 1'b1;
                        end else begin
                            pos_q         <= step_q;
                            pos_valid_q   <= 1'b1;
                            signal_lost_q <= 1'b0;
                        end
                    end else begin
                        wcnt_q  <= wcnt_d;
                        presc_q <= presc_d;
                        step_q  <= step_d;
                        if (wcnt_q == PMAX) begin
                            err_long_q <= 1'b1;
                            state_q    <= WAIT_FALL;
                        end
                    end
                end
                WAIT_FALL: begin
                    if (!sync_w) state_q <= WAIT_RISE;
                end
                default: state_q <= ARM;
            endcase
        end
    end

    assign pos         = pos_q;
    assign pos_valid   = pos_valid_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign signal_lost = signal_lost_q;

endmodule
